// File: rtl/fetch_stage.sv
// IF stage plus the IF/ID pipeline register: PC sequencing, redirect and stall handling, ID/EX bubble request.
// Optional feature: define FETCH_STATS_EN to add saturating redirect and stall counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        ControlHazard,
    input  logic [31:0] RedirectPc,
    input  logic        DataHazardStall,
    input  logic [31:0] InstIn,
    output logic [31:0] IfPc,
    output logic [31:0] IdPc,
    output logic [31:0] IdPc4,
    output logic [31:0] IdInst,
    output logic        IdValid,
    output logic        FlushEx,
    output logic [1:0]  IfState
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] RedirectCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t state;
    logic   do_redirect;
    logic   do_stall;
    logic   redirect_lsb_unused;

    // A redirect overrides a simultaneous stall: the stalled consumer is on the wrong path.
    assign do_redirect = ControlHazard;
    assign do_stall    = DataHazardStall & ~ControlHazard;

    // Both hazards bubble ID/EX in the same cycle they are raised.
    assign FlushEx = ControlHazard | DataHazardStall;
    assign IfState = state;

    // Redirect targets are word-aligned by truncation; the low bits are dropped without a trap.
    assign redirect_lsb_unused = ^RedirectPc[1:0];

    // Every branch below assigns state, so the unused encoding 2'd3 cannot persist past one edge.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            IfPc    <= RESET_PC;
            IdPc    <= '0;
            IdPc4   <= '0;
            IdInst  <= NOP_INST;
            IdValid <= 1'b0;
            state   <= RUN;
        end else if (do_redirect) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, so IfPc+4 and IdPc see the same old IfPc.
            IfPc    <= {RedirectPc[31:2], 2'b00};
            IdInst  <= NOP_INST;
            IdValid <= 1'b0;
            state   <= BUBBLE;
        end else if (do_stall) begin
            state <= HOLD;
        end else begin
            IfPc    <= IfPc + 32'd4;
            IdPc    <= IfPc;
            IdPc4   <= IfPc + 32'd4;
            IdInst  <= InstIn;
            IdValid <= 1'b1;
            state   <= RUN;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            RedirectCount <= '0;
            StallCount    <= '0;
        end else begin
            if (do_redirect && RedirectCount != 32'hFFFF_FFFF) RedirectCount <= RedirectCount + 32'd1;
            if (do_stall && StallCount != 32'hFFFF_FFFF)       StallCount    <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized hazards against a PC-level model.
// Stats counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        ControlHazard = 1'b0;
    logic [31:0] RedirectPc = '0;
    logic        DataHazardStall = 1'b0;
    logic [31:0] InstIn;
    logic [31:0] IfPc, IdPc, IdPc4, IdInst;
    logic        IdValid, FlushEx;
    logic [1:0]  IfState;
`ifdef FETCH_STATS_EN
    logic [31:0] RedirectCount, StallCount;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: architectural view of PC and the ID slot.
    logic [31:0] m_pc, m_idpc, m_idpc4, m_inst;
    logic        m_valid;
    logic [1:0]  m_state;
    logic [31:0] m_rc, m_sc;

    fetch_stage dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst_n       (cpu_rst_n),
        .ControlHazard   (ControlHazard),
        .RedirectPc      (RedirectPc),
        .DataHazardStall (DataHazardStall),
        .InstIn          (InstIn),
        .IfPc            (IfPc),
        .IdPc            (IdPc),
        .IdPc4           (IdPc4),
        .IdInst          (IdInst),
        .IdValid         (IdValid),
        .FlushEx         (FlushEx),
        .IfState         (IfState)
`ifdef FETCH_STATS_EN
        ,
        .RedirectCount   (RedirectCount),
        .StallCount      (StallCount)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    // IROM: word i at byte address 4i, salted so it never equals the NOP encoding.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h5A00_0000 ^ (a >> 2);
    endfunction

    assign InstIn = rom(IfPc);

    function automatic logic [130:0] obs_vec();
        return {IfPc, IdPc, IdPc4, IdInst, IdValid, IfState};
    endfunction

    function automatic logic [130:0] exp_vec();
        return {m_pc, m_idpc, m_idpc4, m_inst, m_valid, m_state};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0; m_inst = NOP;
        m_valid = 1'b0; m_state = 2'd0; m_rc = 32'h0; m_sc = 32'h0;
    endtask

    task automatic model_edge(input logic ch, input logic [31:0] rpc, input logic st);
        if (ch) begin
            m_pc = rpc & ~32'h3;
            m_inst = NOP; m_valid = 1'b0; m_state = 2'd2;
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
        end else if (st) begin
            m_state = 2'd1;
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else begin
            m_idpc = m_pc; m_idpc4 = m_pc + 4; m_inst = rom(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 4; m_state = 2'd0;
        end
    endtask

    task automatic drive(input logic ch, input logic [31:0] rpc, input logic st);
        ControlHazard = ch; RedirectPc = rpc; DataHazardStall = st;
        #1;
    endtask

    task automatic edge_step();
        @(posedge cpu_clk);
        model_edge(ControlHazard, RedirectPc, DataHazardStall);
        #1;
        ControlHazard = 1'b0; DataHazardStall = 1'b0;
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        ControlHazard = 1'b0; DataHazardStall = 1'b0; RedirectPc = '0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        model_reset();
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (obs_vec() !== {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0}) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs_vec(), {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0});
        end
        total++;
        if (FlushEx !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", FlushEx); end
    endtask

    task automatic test_first_instr();
        edge_step();
        total++;
        if (IdPc !== 32'h0 || IdValid !== 1'b1 || IdInst !== rom(32'h0)) begin
            bad++; $display("FAIL first_in_id pc=%h valid=%b inst=%h want pc=0 valid=1 inst=%h", IdPc, IdValid, IdInst, rom(32'h0));
        end
        edge_step();
        edge_step();
        total++;
        if ({IfPc, IdPc, IdPc4, IdValid} !== {32'h0C, 32'h08, 32'h0C, 1'b1}) begin
            bad++; $display("FAIL three_edges if=%h id=%h id4=%h v=%b want 0c/08/0c/1", IfPc, IdPc, IdPc4, IdValid);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL first_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_redirect();
        edge_step();
        drive(1'b1, 32'h200, 1'b0);
        total++;
        if (IfPc !== 32'h10 || FlushEx !== 1'b1) begin
            bad++; $display("FAIL redirect_flush if=%h flush=%b want 10/1", IfPc, FlushEx);
        end
        edge_step();
        total++;
        if ({IfPc, IdValid, IdInst, IfState, IdPc} !== {32'h200, 1'b0, NOP, 2'd2, 32'h0C}) begin
            bad++; $display("FAIL redirect_bubble if=%h v=%b inst=%h st=%0d idpc=%h", IfPc, IdValid, IdInst, IfState, IdPc);
        end
        edge_step();
        total++;
        if ({IdPc, IdPc4, IdValid, IfState} !== {32'h200, 32'h204, 1'b1, 2'd0}) begin
            bad++; $display("FAIL redirect_target idpc=%h id4=%h v=%b st=%0d want 200/204/1/0", IdPc, IdPc4, IdValid, IfState);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h18, 1'b0);
        edge_step();
        edge_step();
        edge_step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            total++;
            if (FlushEx !== 1'b1) begin bad++; $display("FAIL stall_flush cyc=%0d got=%b want=1", i, FlushEx); end
            edge_step();
            total++;
            if ({IfPc, IdPc, IdValid, IdInst, IfState} !== {32'h20, 32'h1C, 1'b1, rom(32'h1C), 2'd1}) begin
                bad++; $display("FAIL stall_hold cyc=%0d if=%h id=%h v=%b st=%0d want 20/1c/1/1", i, IfPc, IdPc, IdValid, IfState);
            end
        end
        edge_step();
        total++;
        if ({IfPc, IdPc, IfState} !== {32'h24, 32'h20, 2'd0}) begin
            bad++; $display("FAIL stall_resume if=%h id=%h st=%0d want 24/20/0", IfPc, IdPc, IfState);
        end
    endtask

    task automatic test_both();
`ifdef FETCH_STATS_EN
        logic [31:0] rc0, sc0;
        rc0 = RedirectCount; sc0 = StallCount;
`endif
        drive(1'b1, 32'h103, 1'b1);
        edge_step();
        total++;
        if ({IfPc, IdValid, IfState} !== {32'h100, 1'b0, 2'd2}) begin
            bad++; $display("FAIL both_redirect if=%h v=%b st=%0d want 100/0/2", IfPc, IdValid, IfState);
        end
`ifdef FETCH_STATS_EN
        total++;
        if (RedirectCount !== rc0 + 1 || StallCount !== sc0) begin
            bad++; $display("FAIL both_stats rc=%0d sc=%0d want %0d/%0d", RedirectCount, StallCount, rc0 + 1, sc0);
        end
`endif
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0);
        edge_step();
        edge_step();
        total++;
        if ({IfPc, IdPc, IdPc4} !== {32'h0, 32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL wrap if=%h id=%h id4=%h want 0/fffffffc/0", IfPc, IdPc, IdPc4);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h300, 1'b0);
        edge_step();
        drive(1'b1, 32'h404, 1'b0);
        edge_step();
        total++;
        if ({IfPc, IdValid, IfState} !== {32'h404, 1'b0, 2'd2}) begin
            bad++; $display("FAIL b2b_last if=%h v=%b st=%0d want 404/0/2", IfPc, IdValid, IfState);
        end
        edge_step();
        total++;
        if ({IdPc, IdValid, IfPc} !== {32'h404, 1'b1, 32'h408}) begin
            bad++; $display("FAIL b2b_target id=%h v=%b if=%h want 404/1/408", IdPc, IdValid, IfPc);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL b2b_model got=%h want=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        logic ch, st;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            ch  = ($urandom_range(0, 4) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rpc = $urandom;
            drive(ch, rpc, st);
            total++;
            if (FlushEx !== (ch | st)) begin bad++; $display("FAIL rand_flush i=%0d got=%b want=%b", i, FlushEx, ch | st); end
            edge_step();
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rand_state i=%0d got=%h want=%h", i, obs_vec(), exp_vec()); end
`ifdef FETCH_STATS_EN
            total++;
            if (RedirectCount !== m_rc || StallCount !== m_sc) begin
                bad++; $display("FAIL rand_stats i=%0d rc=%0d sc=%0d want %0d/%0d", i, RedirectCount, StallCount, m_rc, m_sc);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        edge_step();
        edge_step();
        drive(1'b0, 32'h0, 1'b1);
        edge_step();
        drive(1'b0, 32'h0, 1'b1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec() !== {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0}) begin
            bad++; $display("FAIL async_reset got=%h want=%h", obs_vec(), {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0});
        end
`ifdef FETCH_STATS_EN
        total++;
        if (RedirectCount !== 32'h0 || StallCount !== 32'h0) begin
            bad++; $display("FAIL async_reset_stats rc=%0d sc=%0d want 0/0", RedirectCount, StallCount);
        end
`endif
        DataHazardStall = 1'b0;
        do_reset();
        edge_step();
        total++;
        if ({IdPc, IdValid, IfPc} !== {32'h0, 1'b1, 32'h4}) begin
            bad++; $display("FAIL post_reset id=%h v=%b if=%h want 0/1/4", IdPc, IdValid, IfPc);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_instr();
        test_redirect();
        test_stall();
        test_both();
        test_wrap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
